// File: rtl/tdc_pkg.sv
// tdc_pkg: shared types and defaults for the TDC hamming-weight statistics block
package tdc_pkg;
  localparam int HW_W_DEF = 7;
  localparam int MAX_LOG2_DEF = 10;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  function automatic logic [3:0] clamp_log2(input logic [3:0] w, input int max_log2);
    return (w > 4'(max_log2)) ? 4'(max_log2) : w;
  endfunction
endpackage

// File: rtl/tdc_hw_acc.sv
// tdc_hw_acc: running min/max/sum of hamming-weight samples
module tdc_hw_acc import tdc_pkg::*; #(
  parameter int HW_W  = HW_W_DEF,
  parameter int SUM_W = HW_W_DEF + MAX_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [HW_W-1:0]  sample,
  output logic [HW_W-1:0]  hw_min,
  output logic [HW_W-1:0]  hw_max,
  output logic [SUM_W-1:0] hw_sum
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hw_min <= '1;
      hw_max <= '0;
      hw_sum <= '0;
    end else if (en) begin
      hw_min <= sample < hw_min ? sample : hw_min;
      hw_max <= sample > hw_max ? sample : hw_max;
      hw_sum <= hw_sum + SUM_W'(sample);
    end
  end
endmodule

// File: rtl/tdc_hw_stats.sv
// tdc_hw_stats: windowed min/max/sum/mean of TDC hamming-weight samples with a hold-until-ready result
module tdc_hw_stats import tdc_pkg::*; #(
  parameter int HW_W     = HW_W_DEF,
  parameter int MAX_LOG2 = MAX_LOG2_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [HW_W-1:0]          hw_in,
  input  logic                     hw_valid,
  input  logic                     start,
  input  logic [3:0]               win_log2,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     out_valid,
  output logic [HW_W-1:0]          hw_min,
  output logic [HW_W-1:0]          hw_max,
  output logic [HW_W+MAX_LOG2-1:0] hw_sum,
  output logic [HW_W-1:0]          hw_mean
);
  state_t state, state_nxt;
  logic [MAX_LOG2:0] cnt, target;
  logic [3:0] exp_q;
  logic clr, en, done;
  assign clr = state == IDLE && start;
  assign en = state == ACC && hw_valid;
  assign target = (MAX_LOG2+1)'(1) << exp_q;
  assign done = en && (cnt + (MAX_LOG2+1)'(1)) == target;
  // exponent is latched at start so a changing win_log2 cannot disturb a running window
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      exp_q <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        cnt <= '0;
        exp_q <= clamp_log2(win_log2, MAX_LOG2);
      end else if (en) cnt <= cnt + (MAX_LOG2+1)'(1);
    end
  end
  always_comb begin
    state_nxt = state;
    state_nxt = clr ? ACC : done ? HOLD : (state == HOLD && out_ready) ? IDLE : state;
    busy = state == ACC;
    out_valid = state == HOLD;
  end
  tdc_hw_acc #(.HW_W(HW_W), .SUM_W(HW_W + MAX_LOG2)) u_acc (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en(en),
    .sample(hw_in),
    .hw_min(hw_min),
    .hw_max(hw_max),
    .hw_sum(hw_sum)
  );
  assign hw_mean = HW_W'(hw_sum >> exp_q);
endmodule

// File: tb/tb_tdc_hw_stats.sv
// tb_tdc_hw_stats: scoreboard bench, directed windows checked by a negedge monitor
module tb_tdc_hw_stats;
  localparam int HW_W = 7;
  localparam int MAX_LOG2 = 10;
  logic clk = 0, rst = 1, hw_valid = 0, start = 0, out_ready = 0;
  logic [HW_W-1:0] hw_in = '0;
  logic [3:0] win_log2 = '0;
  logic busy, out_valid;
  logic [HW_W-1:0] hw_min, hw_max, hw_mean;
  logic [HW_W+MAX_LOG2-1:0] hw_sum;
  typedef struct {int mn; int mx; int sm; int mu;} res_t;
  res_t q[$];
  res_t cur;
  bit have = 0;
  int checks = 0, errors = 0, rcv = 0;
  always #5 clk = ~clk;
  tdc_hw_stats #(.HW_W(HW_W), .MAX_LOG2(MAX_LOG2)) dut (
    .clk(clk),
    .rst(rst),
    .hw_in(hw_in),
    .hw_valid(hw_valid),
    .start(start),
    .win_log2(win_log2),
    .out_ready(out_ready),
    .busy(busy),
    .out_valid(out_valid),
    .hw_min(hw_min),
    .hw_max(hw_max),
    .hw_sum(hw_sum),
    .hw_mean(hw_mean)
  );
  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_win(input logic [3:0] w);
    win_log2 = w;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send(input int v);
    hw_in = HW_W'(v);
    hw_valid = 1;
    tick();
    hw_valid = 0;
  endtask
  task automatic release_res(string nm);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk(nm, {busy, out_valid}, 0);
  endtask
  task automatic push(input int mn, input int mx, input int sm, input int mu);
    q.push_back('{mn, mx, sm, mu});
  endtask
  // every cycle a result is presented it must match the expectation popped when it first appeared
  always @(negedge clk) begin
    if (rst || !out_valid) have = 0;
    else begin
      if (!have) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum %0d with no expectation queued", hw_sum);
        end else begin
          cur = q.pop_front();
          have = 1;
          rcv++;
        end
      end
      if (have) begin
        chk("res_min", hw_min, cur.mn);
        chk("res_max", hw_max, cur.mx);
        chk("res_sum", hw_sum, cur.sm);
        chk("res_mean", hw_mean, cur.mu);
        chk("res_busy", busy, 0);
      end
    end
  end
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_min", hw_min, 127);
    chk("rst_max", hw_max, 0);
    chk("rst_sum", hw_sum, 0);
    chk("rst_mean", hw_mean, 0);
    rst = 0;
    tick();
    push(10, 40, 100, 25);
    start_win(2);
    chk("busy_acc", busy, 1);
    send(10); send(20); send(30); send(40);
    chk("latency_w2", out_valid, 1);
    release_res("idle_w2");
    push(127, 127, 127, 127);
    start_win(0);
    send(127);
    chk("latency_w0", out_valid, 1);
    repeat (5) tick();
    chk("hold_w0", out_valid, 1);
    release_res("idle_w0");
    for (int k = 0; k < 2; k++) begin
      push(127, 127, 130048, 127);
      start_win(k == 0 ? 4'd10 : 4'd15);
      for (int i = 0; i < 1024; i++) begin
        repeat ($urandom_range(0, 2)) begin
          hw_in = '0;
          tick();
        end
        send(127);
        if (i == 1022) chk("busy_before_last", busy, 1);
      end
      chk("latency_big", out_valid, 1);
      release_res("idle_big");
    end
    push(5, 7, 12, 6);
    win_log2 = 1;
    start = 1;
    hw_valid = 1;
    hw_in = 99;
    tick();
    start = 0;
    hw_valid = 0;
    send(5);
    win_log2 = 0;
    start = 1;
    tick();
    start = 0;
    chk("start_in_acc", busy, 1);
    send(7);
    chk("latency_w1", out_valid, 1);
    start = 1;
    tick();
    start = 0;
    send(0);
    chk("hold_ignores", out_valid, 1);
    out_ready = 1;
    start = 1;
    tick();
    out_ready = 0;
    start = 0;
    chk("hs_start_ignored", {busy, out_valid}, 0);
    start_win(3);
    send(50); send(60); send(70);
    rst = 1;
    start = 1;
    hw_valid = 1;
    hw_in = 1;
    out_ready = 1;
    tick();
    rst = 0;
    start = 0;
    hw_valid = 0;
    out_ready = 0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", out_valid, 0);
    chk("abort_min", hw_min, 127);
    chk("abort_max", hw_max, 0);
    chk("abort_sum", hw_sum, 0);
    chk("abort_mean", hw_mean, 0);
    push(1, 8, 36, 4);
    start_win(3);
    for (int i = 1; i <= 8; i++) send(i);
    chk("latency_w3", out_valid, 1);
    release_res("idle_w3");
    chk("results_seen", rcv, 6);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
